iiitb_tlc_timed: RTL
====================

// Module: iiitb_tlc_timed
// PURPOSE
//  Parametrised, timed highway/farm-road traffic-light controller; successor to the untimed 4-state TLC.
//  Adds per-phase cycle timers, minimum/maximum green times, all-red clearance, a 2-flop synchroniser on the
//  farm-road sensor and a sticky vehicle request. Sits in the user project area, driven from io_in pads,
//  with lights driven to io_out pads.
// PARAMETERS
//  CNT_W     16  phase-timer width; every T_* below must satisfy 1 <= T_* < 2**CNT_W
//  T_HG_MIN  8   minimum highway-green duration, clk cycles
//  T_YEL     4   yellow duration (both roads), cycles
//  T_AR      2   all-red clearance duration, cycles
//  T_FG_MIN  4   minimum farm-green duration, cycles
//  T_FG_MAX  16  maximum farm-green duration, cycles (T_FG_MAX >= T_FG_MIN)
// PORTS
//  clk            in   1      system clock, all logic on rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  C              in   1      farm-road vehicle sensor, asynchronous to clk
//  light_highway  out  3      {red,yellow,green}, one-hot
//  light_farm     out  3      {red,yellow,green}, one-hot
//  phase          out  3      current state encoding (debug/LA)
// BEHAVIOUR
//  - Reset: state=HG_FR, timer=0, sync flops=0, car_pending=0, light_highway=3'b001, light_farm=3'b100, phase=0.
//    Takes effect immediately, including mid-phase; no partial phase resumes after release.
//  - c_sync = C after two flops (2-cycle latency). car_pending set when c_sync=1 in any state except HR_FG;
//    cleared on entry to HR_FG.
//  - timer clears to 0 on every state change, else increments by 1; never wraps (params bound it).
//  - State / phase / lights (hwy,farm):
//      HG_FR  0 001,100 -> HY_FR when timer>=T_HG_MIN-1 && (car_pending || c_sync); else hold (no max)
//      HY_FR  1 010,100 -> AR1   when timer==T_YEL-1
//      AR1    2 100,100 -> HR_FG when timer==T_AR-1
//      HR_FG  3 100,001 -> HR_FY when (timer>=T_FG_MIN-1 && !c_sync) || timer==T_FG_MAX-1
//      HR_FY  4 100,010 -> AR2   when timer==T_YEL-1
//      AR2    5 100,100 -> HG_FR when timer==T_AR-1
//      codes 6,7 -> HG_FR next cycle, lights 100,100 while there
//  - A fixed phase of length T occupies exactly T cycles. Lights and phase are registered and change on the
//    same edge as state. Green never shown on both roads; every green->red passes yellow then all-red.
//  - Simultaneous: c_sync falling on the cycle timer reaches T_FG_MAX-1 -> exit (single transition).
// CONFIGURATION
//  TLC_PED_EN defined: adds ports ped_req (in,1, async button) and ped_walk (out,1, reset 0).
//    ped_req is 2-flop synchronised and ORed into car_pending; ped_walk=1 exactly while state==HR_FG.
//  TLC_PED_EN undefined: neither port exists; behaviour as above.
// TESTING (T_HG_MIN=4, T_YEL=2, T_AR=1, T_FG_MIN=2, T_FG_MAX=5; edge n = nth rising edge after rst_n release)
//  1. C=0 for 30 cycles -> lights stay 001/100, phase=0 throughout; C=1 during reset -> lights 001/100.
//  2. C=1 held -> phase 1 at edge 4, 2 at 6, 3 at 7, 4 at 12 (T_FG_MAX), 5 at 14, 0 at 15, then repeats.
//  3. C high for one edge only (edge 1) -> car_pending sticks; phase 1 still at edge 4.
//  4. C=1 until phase 3 entered, then C=0 -> phase 4 after timer>=1 and c_sync=0 (2-cycle sync lag), before T_FG_MAX.
//  5. rst_n pulsed low in HY_FR -> lights 001/100, phase 0 asynchronously, before the next clk edge.
//  6. TLC_PED_EN: ped_req pulse with C=0 -> full cycle runs; ped_walk=1 only during phase 3.
//  All tests: assert never both greens, never green-to-red without yellow, one-hot lights every cycle.

Source files
------------

// File: rtl/iiitb_tlc_timed.sv
// ---------------------------------------------------------------------------
// iiitb_tlc_timed
// Timed highway / farm-road traffic-light controller.
//
// The highway rests on green until the minimum green time has elapsed and a
// farm-road vehicle has been seen. The sequence then runs highway yellow,
// all-red, farm green (bounded by a minimum and a maximum), farm yellow and
// all-red, and returns to highway green. The farm-road sensor passes through
// a 2-flop synchroniser. A sticky request remembers a vehicle that went away
// before the highway was ready to yield.
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous, active-low reset
//   C              in   1  farm-road vehicle sensor (asynchronous to clk)
//   light_highway  out  3  {red,yellow,green}, one-hot, registered
//   light_farm     out  3  {red,yellow,green}, one-hot, registered
//   phase          out  3  current state code (debug / logic analyser)
//   ped_req        in   1  pedestrian button, async   (TLC_PED_EN only)
//   ped_walk       out  1  walk lamp, high in HR_FG   (TLC_PED_EN only)
//
// Build option: define TLC_PED_EN to add the pedestrian request/walk ports.
// ---------------------------------------------------------------------------
module iiitb_tlc_timed #(
    parameter int CNT_W    = 16,
    parameter int T_HG_MIN = 8,
    parameter int T_YEL    = 4,
    parameter int T_AR     = 2,
    parameter int T_FG_MIN = 4,
    parameter int T_FG_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       C,
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    output logic [2:0] phase
`ifdef TLC_PED_EN
    ,
    input  logic       ped_req,
    output logic       ped_walk
`endif
);

    localparam logic [2:0] HG_FR = 3'd0;
    localparam logic [2:0] HY_FR = 3'd1;
    localparam logic [2:0] AR1   = 3'd2;
    localparam logic [2:0] HR_FG = 3'd3;
    localparam logic [2:0] HR_FY = 3'd4;
    localparam logic [2:0] AR2   = 3'd5;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    // Timer value seen on the last cycle of each phase.
    localparam logic [CNT_W-1:0] HG_MIN_LAST = CNT_W'(T_HG_MIN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(T_AR - 1);
    localparam logic [CNT_W-1:0] FG_MIN_LAST = CNT_W'(T_FG_MIN - 1);
    localparam logic [CNT_W-1:0] FG_MAX_LAST = CNT_W'(T_FG_MAX - 1);

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] timer_reg;
    logic             c_meta_reg, c_sync_reg;
    logic             car_pending_reg, car_pending_next;
    logic [2:0]       hwy_next, farm_next;
    logic             state_change;
    logic             request_in;

`ifdef TLC_PED_EN
    logic ped_meta_reg, ped_sync_reg;
    assign request_in = c_sync_reg | ped_sync_reg;
`else
    assign request_in = c_sync_reg;
`endif

    // Next-state logic: timer counts cycles already spent in the phase minus one.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HG_FR: if (timer_reg >= HG_MIN_LAST && (car_pending_reg || c_sync_reg))
                       state_next = HY_FR;
            HY_FR: if (timer_reg == YEL_LAST) state_next = AR1;
            AR1:   if (timer_reg == AR_LAST)  state_next = HR_FG;
            // Max-time exit wins even if the sensor drops on the same cycle;
            // either way it is a single transition.
            HR_FG: if ((timer_reg >= FG_MIN_LAST && !c_sync_reg) || timer_reg == FG_MAX_LAST)
                       state_next = HR_FY;
            HR_FY: if (timer_reg == YEL_LAST) state_next = AR2;
            AR2:   if (timer_reg == AR_LAST)  state_next = HG_FR;
            default: state_next = HG_FR;   // recover from illegal codes
        endcase
    end

    assign state_change = (state_next != state_reg);

    // Lights are decoded from the next state so they register on the same
    // edge as the state itself. Illegal codes show all red.
    always_comb begin
        hwy_next  = L_RED;
        farm_next = L_RED;
        case (state_next)
            HG_FR: hwy_next  = L_GRN;
            HY_FR: hwy_next  = L_YEL;
            HR_FG: farm_next = L_GRN;
            HR_FY: farm_next = L_YEL;
            default: ;
        endcase
    end

    // The request is consumed when the farm road is granted green; a vehicle
    // seen while farm green is already showing does not re-arm it.
    always_comb begin
        car_pending_next = car_pending_reg;
        if (state_change && state_next == HR_FG)
            car_pending_next = 1'b0;
        else if (state_reg != HR_FG && request_in)
            car_pending_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= HG_FR;
            timer_reg       <= '0;
            c_meta_reg      <= 1'b0;
            c_sync_reg      <= 1'b0;
            car_pending_reg <= 1'b0;
            light_highway   <= L_GRN;
            light_farm      <= L_RED;
        end else begin
            state_reg       <= state_next;
            c_meta_reg      <= C;
            c_sync_reg      <= c_meta_reg;
            car_pending_reg <= car_pending_next;
            light_highway   <= hwy_next;
            light_farm      <= farm_next;
            // Highway green has no maximum, so saturate rather than wrap.
            if (state_change)
                timer_reg <= '0;
            else if (!(&timer_reg))
                timer_reg <= timer_reg + CNT_W'(1);
        end
    end

`ifdef TLC_PED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_meta_reg <= 1'b0;
            ped_sync_reg <= 1'b0;
            ped_walk     <= 1'b0;
        end else begin
            ped_meta_reg <= ped_req;
            ped_sync_reg <= ped_meta_reg;
            ped_walk     <= (state_next == HR_FG);
        end
    end
`endif

    assign phase = state_reg;

endmodule
